// File: rtl/multi_channel_capture.sv
`default_nettype none
// ============================================================================
//  Module      : multi_channel_capture
//  Description : NCH-channel lock-step ring-buffer capture with pre/post
//                trigger window and channel-interleaved valid/ready readout.
//  Revision    : 1.0  initial release
// ============================================================================
module multi_channel_capture #(
    parameter  int NCH   = 4,
    parameter  int WIDTH = 12,
    parameter  int SIZE  = 12,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  sample_valid,
    input  logic [NCH*WIDTH-1:0]  sample_data,
    input  logic                  trigger,
    input  logic                  self_trig_en,
    input  logic [WIDTH-1:0]      threshold,
    input  logic [SIZE-1:0]       how_many,
    input  logic [SIZE-1:0]       offset,
    input  logic                  read_request,
    output logic [WIDTH-1:0]      dout,
    output logic [CHW-1:0]        dout_chan,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,
    output logic                  ro_done,
    output logic                  cfg_err,
    output logic [2:0]            state_out
);

    localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_RUNNING  = 3'b010,
        ST_POSTTRIG = 3'b100,
        ST_READY    = 3'b011,
        ST_READOUT  = 3'b001
    } state_t;

    state_t state, state_nxt;

    logic [SIZE-1:0]      hm_q;
    logic [SIZE-1:0]      off_q;
    logic [SIZE-1:0]      post_len;
    logic [SIZE-1:0]      wr_ptr;
    logic [SIZE-1:0]      pre_cnt;
    logic [SIZE-1:0]      post_cnt;
    logic [SIZE-1:0]      trig_addr;
    logic [SIZE-1:0]      rd_addr;
    logic [SIZE-1:0]      samp_idx;
    logic [CHW-1:0]       chan;
    logic                 prime;
    logic [NCH*WIDTH-1:0] rd_flat;
    logic [NCH-1:0]       thr_hit;

    logic                 cfg_ok;
    logic                 trig_cond;
    logic                 accept;
    logic                 last_word;
    logic                 wr_en;
    logic                 rd_en;
    logic [SIZE-1:0]      post_nxt;
    logic [SIZE-1:0]      hm_m1;

    assign cfg_ok    = (how_many != '0) && (offset < how_many);
    assign trig_cond = (state == ST_RUNNING) && sample_valid && (pre_cnt >= off_q) &&
                       (trigger || (self_trig_en && (|thr_hit)));
    assign post_nxt  = post_cnt + 1'b1;
    assign hm_m1     = hm_q - 1'b1;
    assign accept    = dout_valid && dout_ready;
    assign last_word = (samp_idx == hm_m1) && (chan == LAST_CH);
    assign wr_en     = sample_valid && !abort &&
                       ((state == ST_RUNNING) || (state == ST_POSTTRIG));
    // One RAM read per sample: at readout start, then whenever the final
    // channel of a sample is consumed, so the next sample lands with no bubble.
    assign rd_en     = (state == ST_READOUT) && !abort &&
                       (prime || (accept && (chan == LAST_CH) && !last_word));

    // Per-channel ring buffers written in lock-step, read with a registered port.
    for (genvar k = 0; k < NCH; k++) begin : g_chan
        logic [WIDTH-1:0] ram [2**SIZE];
        logic [WIDTH-1:0] rd_q;

        assign thr_hit[k]                  = (sample_data[k*WIDTH +: WIDTH] >= threshold);
        assign rd_flat[k*WIDTH +: WIDTH]   = rd_q;

        // Capture write port.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                ram[wr_ptr] <= sample_data[k*WIDTH +: WIDTH];
            end
        end

        // Registered read port; held while the current sample is being streamed.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_q <= '0;
            end else if (rd_en) begin
                rd_q <= ram[rd_addr];
            end
        end
    end

    assign dout      = rd_flat[int'(chan)*WIDTH +: WIDTH];
    assign dout_chan = chan;
    assign dout_last = dout_valid && last_word;
    assign state_out = state;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort dominates every other request.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm && cfg_ok) state_nxt = ST_RUNNING;
                end
                ST_RUNNING: begin
                    if (trig_cond) begin
                        state_nxt = (post_len == SIZE'(1)) ? ST_READY : ST_POSTTRIG;
                    end
                end
                ST_POSTTRIG: begin
                    if (sample_valid && (post_nxt == post_len)) state_nxt = ST_READY;
                end
                ST_READY: begin
                    if (read_request) state_nxt = ST_READOUT;
                end
                ST_READOUT: begin
                    if (accept && last_word) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Capture pointers, window counters and readout stream control.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hm_q       <= '0;
            off_q      <= '0;
            post_len   <= '0;
            wr_ptr     <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            trig_addr  <= '0;
            rd_addr    <= '0;
            samp_idx   <= '0;
            chan       <= '0;
            prime      <= 1'b0;
            dout_valid <= 1'b0;
            ro_done    <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            ro_done <= 1'b0;
            cfg_err <= 1'b0;
            if (abort) begin
                dout_valid <= 1'b0;
                prime      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (arm) begin
                            hm_q     <= how_many;
                            off_q    <= offset;
                            post_len <= how_many - offset;
                            if (cfg_ok) begin
                                wr_ptr  <= '0;
                                pre_cnt <= '0;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    ST_RUNNING: begin
                        if (sample_valid) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (pre_cnt < off_q) pre_cnt <= pre_cnt + 1'b1;
                            if (trig_cond) begin
                                trig_addr <= wr_ptr;
                                post_cnt  <= SIZE'(1);
                            end
                        end
                    end
                    ST_POSTTRIG: begin
                        if (sample_valid) begin
                            wr_ptr   <= wr_ptr + 1'b1;
                            post_cnt <= post_nxt;
                        end
                    end
                    ST_READY: begin
                        if (read_request) begin
                            rd_addr  <= trig_addr - off_q;
                            samp_idx <= '0;
                            chan     <= '0;
                            prime    <= 1'b1;
                        end
                    end
                    ST_READOUT: begin
                        if (prime) begin
                            prime      <= 1'b0;
                            dout_valid <= 1'b1;
                            rd_addr    <= rd_addr + 1'b1;
                        end else if (accept) begin
                            if (last_word) begin
                                dout_valid <= 1'b0;
                                ro_done    <= 1'b1;
                            end else if (chan == LAST_CH) begin
                                chan     <= '0;
                                samp_idx <= samp_idx + 1'b1;
                                rd_addr  <= rd_addr + 1'b1;
                            end else begin
                                chan <= chan + 1'b1;
                            end
                        end
                    end
                    default: begin
                        dout_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_channel_capture
//  Description : Directed self-checking bench for multi_channel_capture
//                (NCH=4, WIDTH=12, SIZE=4 so ring wrap is reachable).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multi_channel_capture;

    localparam int NCH   = 4;
    localparam int WIDTH = 12;
    localparam int SIZE  = 4;
    localparam int DEPTH = 16;

    logic                 clk;
    logic                 reset_n;
    logic                 arm;
    logic                 abort;
    logic                 sample_valid;
    logic [NCH*WIDTH-1:0] sample_data;
    logic                 trigger;
    logic                 self_trig_en;
    logic [WIDTH-1:0]     threshold;
    logic [SIZE-1:0]      how_many;
    logic [SIZE-1:0]      offset;
    logic                 read_request;
    logic [WIDTH-1:0]     dout;
    logic [1:0]           dout_chan;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 dout_last;
    logic                 ro_done;
    logic                 cfg_err;
    logic [2:0]           state_out;

    int errors = 0;
    int checks = 0;
    int wcount = 0;
    logic [WIDTH-1:0] exp_mem [DEPTH][NCH];

    multi_channel_capture #(.NCH(NCH), .WIDTH(WIDTH), .SIZE(SIZE)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .arm          (arm),
        .abort        (abort),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .trigger      (trigger),
        .self_trig_en (self_trig_en),
        .threshold    (threshold),
        .how_many     (how_many),
        .offset       (offset),
        .read_request (read_request),
        .dout         (dout),
        .dout_chan    (dout_chan),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_last    (dout_last),
        .ro_done      (ro_done),
        .cfg_err      (cfg_err),
        .state_out    (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_cfg(input int hm, input int off);
        how_many = hm[SIZE-1:0];
        offset   = off[SIZE-1:0];
        arm      = 1'b1;
        step();
        arm      = 1'b0;
        wcount   = 0;
    endtask

    // Ramp sample n: channel k = 16*n+k; ch2v >= 0 overrides channel 2.
    task automatic wr(input int n, input bit trig, input int ch2v, input bit store);
        for (int k = 0; k < NCH; k++) begin
            int v;
            v = 16 * n + k;
            if (k == 2 && ch2v >= 0) v = ch2v;
            sample_data[k*WIDTH +: WIDTH] = v[WIDTH-1:0];
            if (store) exp_mem[wcount % DEPTH][k] = v[WIDTH-1:0];
        end
        sample_valid = 1'b1;
        trigger      = trig;
        step();
        sample_valid = 1'b0;
        trigger      = 1'b0;
        if (store) wcount++;
    endtask

    task automatic readout(input int start, input int hm, input bit rnd, input int abort_after);
        int w;
        int cyc;
        read_request = 1'b1;
        dout_ready   = 1'b1;
        step();
        read_request = 1'b0;
        check("ro_state", {29'd0, state_out}, 32'h1);
        check("lat1_valid", {31'd0, dout_valid}, 32'h0);
        step();
        check("lat2_valid", {31'd0, dout_valid}, 32'h1);
        w   = 0;
        cyc = 0;
        while (w < hm * NCH && cyc < 2000) begin
            logic [15:0] expv;
            logic [1:0]  kk;
            int          a;
            if (abort_after >= 0 && w == abort_after) break;
            a    = (start + w / NCH) % DEPTH;
            kk   = w[1:0];
            expv = {1'b1, kk, (w == hm * NCH - 1) ? 1'b1 : 1'b0, exp_mem[a][w % NCH]};
            check("word", {16'd0, dout_valid, dout_chan, dout_last, dout}, {16'd0, expv});
            dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            cyc++;
            if (dout_ready) w++;
        end
        if (abort_after >= 0) begin
            check("abort_reached", w, abort_after);
            abort      = 1'b1;
            dout_ready = 1'b0;
            step();
            abort = 1'b0;
            check("abort_state", {27'd0, state_out, dout_valid, ro_done}, 32'h0);
            step();
            check("abort_nodone", {28'd0, state_out, ro_done}, 32'h0);
        end else begin
            check("ro_count", w, hm * NCH);
            check("ro_done", {27'd0, state_out, dout_valid, ro_done}, 32'h1);
            step();
            check("ro_done_pulse", {31'd0, ro_done}, 32'h0);
        end
        dout_ready = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        arm          = 1'b0;
        abort        = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        trigger      = 1'b0;
        self_trig_en = 1'b0;
        threshold    = '0;
        how_many     = '0;
        offset       = '0;
        read_request = 1'b0;
        dout_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", {10'd0, state_out, dout_valid, dout_last, ro_done, cfg_err, dout_chan, dout},
              32'h0);
        reset_n = 1'b1;
        step();

        // Bad configurations are rejected.
        arm_cfg(4, 4);
        check("cfg_off_eq_hm", {28'd0, state_out, cfg_err}, 32'h1);
        step();
        check("cfg_err_pulse", {31'd0, cfg_err}, 32'h0);
        arm_cfg(0, 0);
        check("cfg_hm_zero", {28'd0, state_out, cfg_err}, 32'h1);
        read_request = 1'b1;
        step();
        read_request = 1'b0;
        check("rdreq_in_idle", {29'd0, state_out}, 32'h0);

        // Basic window: trigger on write 6, window samples 3..10.
        arm_cfg(8, 3);
        check("t1_running", {29'd0, state_out}, 32'h2);
        wr(1, 0, -1, 1);
        wr(2, 0, -1, 1);
        how_many = '0;
        arm      = 1'b1;
        step();
        arm      = 1'b0;
        check("arm_ignored", {28'd0, state_out, cfg_err}, 32'h4);
        for (int n = 3; n <= 5; n++) wr(n, 0, -1, 1);
        wr(6, 1, -1, 1);
        check("t1_posttrig", {29'd0, state_out}, 32'h4);
        for (int n = 7; n <= 9; n++) wr(n, 0, -1, 1);
        check("t1_still_post", {29'd0, state_out}, 32'h4);
        wr(10, 0, -1, 1);
        check("t1_ready", {29'd0, state_out}, 32'h3);
        wr(11, 1, -1, 0);
        check("t1_frozen", {29'd0, state_out}, 32'h3);
        readout(2, 8, 0, -1);

        // Early triggers ignored until offset pre-samples are held.
        arm_cfg(8, 5);
        for (int n = 1; n <= 4; n++) wr(n, 1, -1, 1);
        check("t3_early_ignored", {29'd0, state_out}, 32'h2);
        wr(5, 0, -1, 1);
        wr(6, 0, -1, 1);
        wr(7, 1, -1, 1);
        check("t3_posttrig", {29'd0, state_out}, 32'h4);
        wr(8, 0, -1, 1);
        wr(9, 0, -1, 1);
        check("t3_ready", {29'd0, state_out}, 32'h3);
        readout(1, 8, 0, -1);

        // Ring wrap: 30 writes, trigger on write 31 at address 14.
        arm_cfg(10, 6);
        for (int n = 1; n <= 30; n++) wr(n, 0, -1, 1);
        check("t4_running", {29'd0, state_out}, 32'h2);
        wr(31, 1, -1, 1);
        for (int n = 32; n <= 34; n++) wr(n, 0, -1, 1);
        check("t4_ready", {29'd0, state_out}, 32'h3);
        readout(8, 10, 0, -1);

        // Self trigger on ch2 at threshold; one LSB below must not fire.
        self_trig_en = 1'b1;
        threshold    = 12'h800;
        arm_cfg(4, 1);
        wr(1, 0, -1, 1);
        wr(2, 0, 12'h7ff, 1);
        check("t5_below_thr", {29'd0, state_out}, 32'h2);
        wr(3, 0, 12'h800, 1);
        check("t5_self_trig", {29'd0, state_out}, 32'h4);
        wr(4, 0, -1, 1);
        wr(5, 0, -1, 1);
        check("t5_ready", {29'd0, state_out}, 32'h3);
        self_trig_en = 1'b0;
        readout(1, 4, 0, -1);

        // Random backpressure, then abort partway through readout.
        arm_cfg(4, 1);
        wr(1, 0, -1, 1);
        wr(2, 1, -1, 1);
        wr(3, 0, -1, 1);
        wr(4, 0, -1, 1);
        check("t6_ready", {29'd0, state_out}, 32'h3);
        readout(0, 4, 1, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
